// File: rtl/oc_bank_arbiter_if.sv
// Operand-collector request/grant bundle between the collectors and the bank arbiter.
// The master side is the collectors plus writeback; the slave side is the arbiter.
interface oc_bank_arbiter_if;
  logic [7:0]  req_vld;
  logic [39:0] req_reg_id;
  logic        wb_en;
  logic [4:0]  wb_reg_id;

  logic [7:0]  req_ack;
  logic [3:0]  bk_rd_en;
  logic [11:0] bk_rd_addr;

  logic [2:0]  bk_0_ocid;
  logic [2:0]  bk_1_ocid;
  logic [2:0]  bk_2_ocid;
  logic [2:0]  bk_3_ocid;
  logic        bk_0_vld;
  logic        bk_1_vld;
  logic        bk_2_vld;
  logic        bk_3_vld;
  logic        bk_0_bz;
  logic        bk_1_bz;
  logic        bk_2_bz;
  logic        bk_3_bz;

  modport master (
    output req_vld, req_reg_id, wb_en, wb_reg_id,
    input  req_ack, bk_rd_en, bk_rd_addr,
    input  bk_0_ocid, bk_1_ocid, bk_2_ocid, bk_3_ocid,
    input  bk_0_vld, bk_1_vld, bk_2_vld, bk_3_vld,
    input  bk_0_bz, bk_1_bz, bk_2_bz, bk_3_bz
  );

  modport slave (
    input  req_vld, req_reg_id, wb_en, wb_reg_id,
    output req_ack, bk_rd_en, bk_rd_addr,
    output bk_0_ocid, bk_1_ocid, bk_2_ocid, bk_3_ocid,
    output bk_0_vld, bk_1_vld, bk_2_vld, bk_3_vld,
    output bk_0_bz, bk_1_bz, bk_2_bz, bk_3_bz
  );
endinterface

// File: rtl/oc_bank_arbiter.sv
// Four-bank register-file read arbiter: per-bank round-robin over eight operand sources,
// writeback steals a bank for a cycle, and results are delayed one cycle to line up with SRAM data.
module oc_bank_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  oc_bank_arbiter_if.slave     bus,
  output logic [CNT_W-1:0]     conflict_cnt
);

  logic [2:0] ptr [4];
  logic [7:0] compete [4];
  logic [2:0] winner [4];
  logic [3:0] found;
  logic [3:0] blocked;
  logic [3:0] grant;
  logic       lost;

  logic [3:0] vld_q;
  logic [3:0] bz_q;
  logic [2:0] ocid_q [4];

  // Grants are combinational so the SRAM read starts in the same cycle as the request.
  always_comb begin
    lost = 1'b0;
    bus.req_ack = '0;
    bus.bk_rd_en = '0;
    bus.bk_rd_addr = '0;
    for (int b = 0; b < 4; b++) begin
      compete[b] = '0;
      winner[b] = '0;
      found[b] = 1'b0;
      blocked[b] = bus.wb_en && (bus.wb_reg_id[4:3] == 2'(b));
      for (int i = 0; i < 8; i++)
        compete[b][i] = bus.req_vld[i] && (bus.req_reg_id[5*i+3 +: 2] == 2'(b));
      for (int k = 0; k < 8; k++) begin
        if (!found[b] && compete[b][3'(ptr[b] + 3'(k))]) begin
          found[b] = 1'b1;
          winner[b] = 3'(ptr[b] + 3'(k));
        end
      end
      grant[b] = found[b] && !blocked[b] && rst;
      if (grant[b]) begin
        bus.req_ack[winner[b]] = 1'b1;
        bus.bk_rd_en[b] = 1'b1;
        bus.bk_rd_addr[3*b +: 3] = bus.req_reg_id[5*winner[b] +: 3];
      end
      // Any competitor left waiting counts, whether it lost to a peer or to writeback.
      if ((|compete[b]) && (blocked[b] || ((compete[b] & (compete[b] - 8'd1)) != 8'd0)))
        lost = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) begin
        ptr[b] <= '0;
        ocid_q[b] <= '0;
      end
      vld_q <= '0;
      bz_q <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (grant[b]) begin
          ptr[b] <= 3'(winner[b] + 3'd1);
          ocid_q[b] <= winner[b];
        end
      end
      vld_q <= grant;
      bz_q <= blocked;
      if (lost && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  assign bus.bk_0_vld  = vld_q[0];
  assign bus.bk_1_vld  = vld_q[1];
  assign bus.bk_2_vld  = vld_q[2];
  assign bus.bk_3_vld  = vld_q[3];
  assign bus.bk_0_bz   = bz_q[0];
  assign bus.bk_1_bz   = bz_q[1];
  assign bus.bk_2_bz   = bz_q[2];
  assign bus.bk_3_bz   = bz_q[3];
  assign bus.bk_0_ocid = ocid_q[0];
  assign bus.bk_1_ocid = ocid_q[1];
  assign bus.bk_2_ocid = ocid_q[2];
  assign bus.bk_3_ocid = ocid_q[3];

endmodule

// File: tb/tb_oc_bank_arbiter.sv
// Directed bench for oc_bank_arbiter: same-cycle grants are checked inline, bank returns
// go through a scoreboard queue drained by an independent monitor.
module tb_oc_bank_arbiter;

  typedef struct {
    int         bank;
    logic       vld;
    logic       bz;
    logic [2:0] ocid;
  } ev_t;

  logic       clk;
  logic       rst;
  logic [3:0] cnt;
  int         compares;
  int         fails;
  ev_t        sb [$];

  oc_bank_arbiter_if bus ();

  oc_bank_arbiter #(.CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .conflict_cnt (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compares++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int bank, input logic bz, input logic [2:0] ocid);
    ev_t e;
    e.bank = bank;
    e.vld = !bz;
    e.bz = bz;
    e.ocid = ocid;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] vld, input logic [39:0] ids,
                               input logic wbe, input logic [4:0] wbid);
    @(posedge clk);
    #1;
    bus.req_vld = vld;
    bus.req_reg_id = ids;
    bus.wb_en = wbe;
    bus.wb_reg_id = wbid;
  endtask

  function automatic logic [39:0] putId(input logic [39:0] base, input int src, input logic [4:0] id);
    logic [39:0] r;
    r = base;
    r[5*src +: 5] = id;
    return r;
  endfunction

  // Monitor: every bank reporting data or busy must match the oldest expected return.
  always @(negedge clk) begin
    logic [3:0] v;
    logic [3:0] z;
    logic [2:0] o [4];
    ev_t e;
    v = {bus.bk_3_vld, bus.bk_2_vld, bus.bk_1_vld, bus.bk_0_vld};
    z = {bus.bk_3_bz, bus.bk_2_bz, bus.bk_1_bz, bus.bk_0_bz};
    o[0] = bus.bk_0_ocid;
    o[1] = bus.bk_1_ocid;
    o[2] = bus.bk_2_ocid;
    o[3] = bus.bk_3_ocid;
    for (int b = 0; b < 4; b++) begin
      if (v[b] || z[b]) begin
        if (sb.size() == 0) begin
          compares++;
          fails++;
          $display("[TB] FAIL unexpected bank %0d return: vld=%0b bz=%0b ocid=%0d, expected none", b, v[b], z[b], o[b]);
        end else begin
          e = sb.pop_front();
          compares++;
          if (e.bank != b || {v[b], z[b], o[b]} !== {e.vld, e.bz, e.ocid}) begin
            fails++;
            $display("[TB] FAIL bank return: got bank %0d vld=%0b bz=%0b ocid=%0d, expected bank %0d vld=%0b bz=%0b ocid=%0d",
                     b, v[b], z[b], o[b], e.bank, e.vld, e.bz, e.ocid);
          end
        end
      end
    end
  end

  initial begin
    logic [39:0] ids;
    compares = 0;
    fails = 0;
    rst = 1'b0;
    bus.wb_en = 1'b0;
    bus.wb_reg_id = '0;
    bus.req_vld = 8'h08;
    bus.req_reg_id = putId('0, 3, 5'b10_101);

    repeat (2) @(negedge clk);
    checkOutput("reset_ack", 32'(bus.req_ack), 32'h00);
    checkOutput("reset_rd_en", 32'(bus.bk_rd_en), 32'h0);
    checkOutput("reset_cnt", 32'(cnt), 32'h0);
    checkOutput("reset_vld", 32'(bus.bk_2_vld), 32'h0);

    applyStimulus(8'h00, '0, 1'b0, 5'd0);
    rst = 1'b1;

    // Single request
    applyStimulus(8'h08, putId('0, 3, 5'b10_101), 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("single_ack", 32'(bus.req_ack), 32'h08);
    checkOutput("single_rd_en", 32'(bus.bk_rd_en), 32'h4);
    checkOutput("single_row", 32'(bus.bk_rd_addr[8:6]), 32'd5);
    pushExp(2, 1'b0, 3'd3);

    // Two sources on bank 0
    ids = putId(putId('0, 1, 5'b00_001), 6, 5'b00_110);
    applyStimulus(8'h42, ids, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("conflict_ack1", 32'(bus.req_ack), 32'h02);
    checkOutput("conflict_row1", 32'(bus.bk_rd_addr[2:0]), 32'd1);
    pushExp(0, 1'b0, 3'd1);
    applyStimulus(8'h40, ids, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("conflict_ack2", 32'(bus.req_ack), 32'h40);
    checkOutput("conflict_row2", 32'(bus.bk_rd_addr[2:0]), 32'd6);
    checkOutput("conflict_cnt1", 32'(cnt), 32'd1);
    pushExp(0, 1'b0, 3'd6);

    // Pointer now 7: src7 must beat src0
    ids = putId(putId('0, 0, 5'b00_000), 7, 5'b00_111);
    applyStimulus(8'h81, ids, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("ptr7_ack", 32'(bus.req_ack), 32'h80);
    pushExp(0, 1'b0, 3'd7);
    applyStimulus(8'h01, ids, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("ptr7_ack2", 32'(bus.req_ack), 32'h01);
    checkOutput("conflict_cnt2", 32'(cnt), 32'd2);
    pushExp(0, 1'b0, 3'd0);

    // Writeback steals bank 3
    ids = putId('0, 2, 5'b11_010);
    applyStimulus(8'h04, ids, 1'b1, 5'b11_000);
    @(negedge clk);
    checkOutput("wb_ack", 32'(bus.req_ack), 32'h00);
    checkOutput("wb_rd_en", 32'(bus.bk_rd_en), 32'h0);
    pushExp(3, 1'b1, 3'd0);
    applyStimulus(8'h04, ids, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("wb_retry_ack", 32'(bus.req_ack), 32'h04);
    checkOutput("wb_retry_rd_en", 32'(bus.bk_rd_en), 32'h8);
    checkOutput("wb_retry_row", 32'(bus.bk_rd_addr[11:9]), 32'd2);
    checkOutput("wb_cnt", 32'(cnt), 32'd3);
    pushExp(3, 1'b0, 3'd2);

    // Four banks in parallel
    ids = putId(putId(putId(putId('0, 0, 5'b00_011), 2, 5'b01_010), 4, 5'b10_100), 6, 5'b11_111);
    applyStimulus(8'h55, ids, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("par_ack", 32'(bus.req_ack), 32'h55);
    checkOutput("par_rd_en", 32'(bus.bk_rd_en), 32'hF);
    checkOutput("par_addr", 32'(bus.bk_rd_addr), 32'hF13);
    pushExp(0, 1'b0, 3'd0);
    pushExp(1, 1'b0, 3'd2);
    pushExp(2, 1'b0, 3'd4);
    pushExp(3, 1'b0, 3'd6);
    applyStimulus(8'h00, '0, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("par_cnt", 32'(cnt), 32'd3);

    // Saturation: src1/src6 hold requests and alternate wins, 19 conflict cycles
    ids = putId(putId('0, 1, 5'b00_001), 6, 5'b00_110);
    for (int k = 0; k < 19; k++) begin
      applyStimulus(8'h42, ids, 1'b0, 5'd0);
      @(negedge clk);
      checkOutput("sat_ack", 32'(bus.req_ack), (k % 2 == 0) ? 32'h02 : 32'h40);
      pushExp(0, 1'b0, (k % 2 == 0) ? 3'd1 : 3'd6);
    end
    applyStimulus(8'h42, ids, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("sat_cnt", 32'(cnt), 32'hF);
    checkOutput("sat_inflight_ack", 32'(bus.req_ack), 32'h40);

    // Reset falls with a grant in flight
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_vld", 32'(bus.bk_0_vld), 32'h0);
    checkOutput("rst_cnt", 32'(cnt), 32'h0);
    checkOutput("rst_ack", 32'(bus.req_ack), 32'h00);
    checkOutput("rst_rd_en", 32'(bus.bk_rd_en), 32'h0);
    @(negedge clk);
    checkOutput("rst_hold_ack", 32'(bus.req_ack), 32'h00);

    // First edge after release grants
    applyStimulus(8'h20, putId('0, 5, 5'b01_110), 1'b0, 5'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ack", 32'(bus.req_ack), 32'h20);
    checkOutput("post_rst_rd_en", 32'(bus.bk_rd_en), 32'h2);
    pushExp(1, 1'b0, 3'd5);
    applyStimulus(8'h00, '0, 1'b0, 5'd0);
    repeat (4) @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule

// File: doc/oc_bank_arbiter.md
OC_BANK_ARBITER -- requirements
Module: oc_bank_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the saturating conflict counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset: asynchronous, active-low.
REQ-004 SHALL have port req_vld  input  8  per-source read request; source i = collector i/2, operand i%2, so ocid = i.
REQ-005 SHALL have port req_reg_id  input  40  source i register id in bits [5i+4:5i]; bank = id[4:3], row = id[2:0].
REQ-006 SHALL have port wb_en  input  1  writeback write this cycle, highest priority.
REQ-007 SHALL have port wb_reg_id  input  5  writeback register id.
REQ-008 SHALL have port req_ack  output  8  one-cycle grant pulse per source.
REQ-009 SHALL have port bk_rd_en  output  4  per-bank read enable to the register-file SRAM.
REQ-010 SHALL have port bk_rd_addr  output  12  per-bank row, bits [3b+2:3b].
REQ-011 SHALL have ports bk_0_ocid..bk_3_ocid  output  3 each  source id of the data returned by the bank this cycle.
REQ-012 SHALL have ports bk_0_vld..bk_3_vld  output  1 each  bank data valid this cycle.
REQ-013 SHALL have ports bk_0_bz..bk_3_bz  output  1 each  bank was taken by writeback last cycle.
REQ-014 SHALL have port conflict_cnt  output  CNT_W  saturating arbitration-loss counter.

Function
REQ-015 SHALL treat source i as competing for bank b in cycle N when req_vld[i]=1 and req_reg_id[5i+4:5i+3]=b.
REQ-016 SHALL grant at most one competing source per bank per cycle, combinationally in cycle N: req_ack[i]=1, bk_rd_en[b]=1, bk_rd_addr row = source row.
REQ-017 SHALL select per bank by round-robin: search sources ptr_b, ptr_b+1, ... mod 8; first competitor wins.
REQ-018 SHALL update ptr_b to (winner+1) mod 8 on a grant and leave it unchanged otherwise.
REQ-019 SHALL, when wb_en=1, block reads to bank wb_reg_id[4:3] for that cycle: no grant, no ack, ptr unchanged.
REQ-020 SHALL register the result with 1-cycle latency to match SRAM read latency: in cycle N+1, bk_b_vld=1, bk_b_bz=0, bk_b_ocid=winner if bank b granted in N.
REQ-021 SHALL, in cycle N+1 for a bank blocked by writeback in N, drive bk_b_bz=1, bk_b_vld=0, bk_b_ocid held.
REQ-022 SHALL drive bk_b_vld=0 and bk_b_bz=0 in N+1 for a bank with no competitor and no writeback in N.
REQ-023 SHALL hold bk_b_ocid at its last value when bk_b_vld=0.
REQ-024 SHALL require sources to hold req_vld and req_reg_id until req_ack; deassertion before ack withdraws the request with no side effect.
REQ-025 SHALL grant a source whose req_vld is still high in the cycle after its ack again; collectors drop req_vld on ack.
REQ-026 SHALL increment conflict_cnt by 1 in any cycle where some bank has at least one competitor that is not granted (lost arbitration or writeback block); saturate at all-ones; never wrap.
REQ-027 SHALL let grants to different banks proceed in the same cycle: up to 4 acks per cycle.
REQ-028 SHALL guarantee that a continuously requesting source is granted within 8 non-blocked grant cycles of its bank.

Reset
REQ-029 SHALL, while rst=0, asynchronously force ptr_0..3=0, bk_*_vld=0, bk_*_bz=0, bk_*_ocid=0, conflict_cnt=0.
REQ-030 SHALL, while rst=0, force req_ack=0 and bk_rd_en=0 regardless of requests.
REQ-031 SHALL discard a grant in flight when rst falls; no bk_vld follows after reset release.
REQ-032 SHALL allow grants in the first rising edge after rst returns high.

Verification
REQ-033 SHALL cover single request: src 3, id 5'b10_101, no wb -> same cycle req_ack=8'h08, bk_rd_en=4'b0100, bank2 row 5; next cycle bk_2_vld=1, bk_2_ocid=3, bk_2_bz=0.
REQ-034 SHALL cover conflict: src 1 and src 6 both bank 0, ptr_0=0 -> src1 acked, conflict_cnt +1; next cycle src6 acked; ptr_0=7 after.
REQ-035 SHALL cover writeback steal: src 2 bank 3, wb_en=1 wb_reg_id=5'b11_000 -> no ack, next cycle bk_3_bz=1, bk_3_vld=0; following cycle without wb -> src2 acked.
REQ-036 SHALL cover parallel: srcs 0,2,4,6 on banks 0..3 -> req_ack=8'h55, bk_rd_en=4'hF, all four bk_vld next cycle, conflict_cnt unchanged.
REQ-037 SHALL cover saturation and reset: force 2^CNT_W+3 conflict cycles -> conflict_cnt=all-ones; drop rst mid-grant -> bk_*_vld=0 immediately, conflict_cnt=0.
